axi_read_interface: RTL and testbench

Single-master AXI4 read-channel bridge for the pipelined core. It serialises the two read requesters, instruction fetch (`pc`) and load data (`mm_addr`/`mm_ren`), onto one AR/R channel pair. It returns the fetched instruction with a one-cycle `instr_valid` step pulse that advances the whole pipeline, and returns load data with a one-cycle `rdata_valid` pulse. It sits between the core stages (IFU, MMU) and the external memory model.

---
 rtl/axi_read_interface_pkg.sv | 31 +++
 rtl/axi_read_interface.sv | 186 ++++++++++++++++++
 tb/tb_axi_read_interface.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_interface_pkg.sv
// Shared types and constants for the AXI4 read bridge between the core
// (instruction fetch / load data) and the external memory.
package axi_read_interface_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_D_AR = 3'd1,
        S_D_R  = 3'd2,
        S_I_AR = 3'd3,
        S_I_R  = 3'd4
    } state_e;

    localparam logic [3:0]  ID_INSTR   = 4'd0;
    localparam logic [3:0]  ID_DATA    = 4'd1;
    localparam logic [2:0]  SIZE_W     = 3'b010;
    localparam logic [2:0]  SIZE_D     = 3'b011;
    localparam logic [2:0]  PROT_I     = 3'b100;
    localparam logic [2:0]  PROT_D     = 3'b000;
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    // Pick the 32-bit instruction out of a 64-bit beat using address bit 2.
    function automatic logic [31:0] select_word(input logic hi, input logic [63:0] beat);
        if (hi) begin
            return beat[63:32];
        end else begin
            return beat[31:0];
        end
    endfunction

endpackage

// File: rtl/axi_read_interface.sv
// Serialises load-data and instruction-fetch reads onto one AXI4 AR/R pair,
// one single-beat transfer outstanding at a time.
module axi_read_interface
    import axi_read_interface_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        rdata_valid,
    input  logic [63:0] mm_addr,
    input  logic        mm_ren,
    output logic [63:0] mm_rdata,
    output logic [3:0]  ARID,
    output logic [63:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARLOCK,
    output logic [3:0]  ARCACHE,
    output logic [2:0]  ARPORT,
    output logic [3:0]  ARQOS,
    output logic [3:0]  ARREGION,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [63:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);

    state_e      state_q, state_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [63:0] araddr_q, araddr_d;
    logic [3:0]  arid_q, arid_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [2:0]  arprot_q, arprot_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] mm_rdata_q, mm_rdata_d;
    logic        instr_valid_q, instr_valid_d;
    logic        rdata_valid_q, rdata_valid_d;

    // Every beat is treated as final with usable data, so these carry no information.
    logic        rsp_unused_s;
    assign rsp_unused_s = ^{RID, RRESP, RLAST};

    // Next-state and next-output logic for the request/response sequencer.
    always_comb begin
        state_d       = state_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        araddr_d      = araddr_q;
        arid_d        = arid_q;
        arsize_d      = arsize_q;
        arprot_d      = arprot_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        mm_rdata_d    = mm_rdata_q;
        instr_valid_d = 1'b0;
        rdata_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                pc_d      = pc;
                arvalid_d = 1'b1;
                if (mm_ren) begin
                    state_d  = S_D_AR;
                    araddr_d = mm_addr;
                    arid_d   = ID_DATA;
                    arsize_d = SIZE_D;
                    arprot_d = PROT_D;
                end else begin
                    state_d  = S_I_AR;
                    araddr_d = pc;
                    arid_d   = ID_INSTR;
                    arsize_d = SIZE_W;
                    arprot_d = PROT_I;
                end
            end
            S_D_AR: begin
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_D_R;
                end else begin
                    state_d   = S_D_AR;
                end
            end
            S_D_R: begin
                if (rready_q && RVALID) begin
                    mm_rdata_d    = RDATA;
                    rdata_valid_d = 1'b1;
                    rready_d      = 1'b0;
                    state_d       = S_I_AR;
                end else begin
                    state_d       = S_D_R;
                end
            end
            S_I_AR: begin
                // Entered from a load with ARVALID low: issue the fetch request first.
                if (!arvalid_q) begin
                    arvalid_d = 1'b1;
                    araddr_d  = pc_q;
                    arid_d    = ID_INSTR;
                    arsize_d  = SIZE_W;
                    arprot_d  = PROT_I;
                end else if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_I_R;
                end else begin
                    state_d   = S_I_AR;
                end
            end
            S_I_R: begin
                if (rready_q && RVALID) begin
                    instr_d       = select_word(pc_q[2], RDATA);
                    instr_valid_d = 1'b1;
                    rready_d      = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    state_d       = S_I_R;
                end
            end
            default: begin
                state_d   = S_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            araddr_q      <= 64'd0;
            arid_q        <= 4'd0;
            arsize_q      <= 3'd0;
            arprot_q      <= 3'd0;
            pc_q          <= 64'd0;
            instr_q       <= NOP;
            mm_rdata_q    <= 64'd0;
            instr_valid_q <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            araddr_q      <= araddr_d;
            arid_q        <= arid_d;
            arsize_q      <= arsize_d;
            arprot_q      <= arprot_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            mm_rdata_q    <= mm_rdata_d;
            instr_valid_q <= instr_valid_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign ARVALID     = arvalid_q;
    assign ARADDR      = araddr_q;
    assign ARID        = arid_q;
    assign ARSIZE      = arsize_q;
    assign ARPORT      = arprot_q;
    assign ARLEN       = 8'd0;
    assign ARBURST     = BURST_INCR;
    assign ARLOCK      = 1'b0;
    assign ARCACHE     = 4'd0;
    assign ARQOS       = 4'd0;
    assign ARREGION    = 4'd0;
    assign RREADY      = rready_q;
    assign instr       = instr_q;
    assign mm_rdata    = mm_rdata_q;
    assign instr_valid = instr_valid_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_axi_read_interface.sv
// Scoreboard bench for axi_read_interface: directed steps push expected AR
// requests and result pulses; a negedge monitor pops and compares them.
module tb_axi_read_interface;

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  id;
        logic [2:0]  size;
        logic [2:0]  prot;
    } ar_exp_t;

    typedef struct {
        bit          is_instr;
        logic [63:0] val;
    } out_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc = 64'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        rdata_valid;
    logic [63:0] mm_addr = 64'd0;
    logic        mm_ren = 1'b0;
    logic [63:0] mm_rdata;
    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARLOCK;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPORT;
    logic [3:0]  ARQOS;
    logic [3:0]  ARREGION;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [3:0]  RID = 4'd0;
    logic [63:0] RDATA = 64'd0;
    logic [1:0]  RRESP = 2'd0;
    logic        RLAST = 1'b1;
    logic        RVALID = 1'b0;
    logic        RREADY;

    int checks = 0;
    int errors = 0;

    ar_exp_t  ar_q[$];
    out_exp_t out_q[$];

    int          ar_delay = 0;
    int          r_delay  = 0;
    logic [1:0]  r_resp   = 2'b00;
    logic [63:0] data_i   = 64'd0;
    logic [63:0] data_d   = 64'd0;

    axi_read_interface dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .rdata_valid(rdata_valid), .mm_addr(mm_addr), .mm_ren(mm_ren), .mm_rdata(mm_rdata),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPORT(ARPORT), .ARQOS(ARQOS),
        .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ARREADY after ar_delay cycles, single R beat r_delay cycles after handshake.
    initial begin
        logic [3:0] id;
        forever begin
            @(posedge clk); #1;
            if (!rst && ARVALID) begin
                repeat (ar_delay) begin @(posedge clk); #1; end
                ARREADY = 1'b1;
                id = ARID;
                @(posedge clk); #1;
                ARREADY = 1'b0;
                repeat (r_delay) begin @(posedge clk); #1; end
                RVALID = 1'b1;
                RID    = id;
                RRESP  = r_resp;
                RDATA  = (id == 4'd1) ? data_d : data_i;
                @(posedge clk); #1;
                RVALID = 1'b0;
                RRESP  = 2'b00;
            end
        end
    end

    // Monitor: pops expectations on AR handshakes and result pulses.
    initial begin
        bit          prev_stall = 0;
        bit          prev_iv = 0;
        logic [63:0] prev_addr = 64'd0;
        ar_exp_t     a;
        out_exp_t    o;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                prev_iv    = 0;
            end else begin
                if (prev_stall) begin
                    check64("arvalid_stable", {63'd0, ARVALID}, 64'd1);
                    check64("araddr_stable", ARADDR, prev_addr);
                end
                if (ARVALID && ARREADY) begin
                    if (ar_q.size() == 0) begin
                        check64("unexpected_ar", ARADDR, 64'd0 - 64'd1);
                    end else begin
                        a = ar_q.pop_front();
                        check64("araddr", ARADDR, a.addr);
                        check64("arid", {60'd0, ARID}, {60'd0, a.id});
                        check64("arsize", {61'd0, ARSIZE}, {61'd0, a.size});
                        check64("arprot", {61'd0, ARPORT}, {61'd0, a.prot});
                        check64("ar_consts", {ARLEN, ARBURST, ARLOCK, ARCACHE, ARQOS, ARREGION},
                                {8'd0, 2'b01, 1'b0, 4'd0, 4'd0, 4'd0});
                    end
                end
                if (instr_valid) begin
                    check64("instr_valid_width", {63'd0, prev_iv}, 64'd0);
                    if (out_q.size() == 0 || !out_q[0].is_instr) begin
                        check64("unexpected_instr_valid", {32'd0, instr}, 64'd0 - 64'd1);
                    end else begin
                        o = out_q.pop_front();
                        check64("instr", {32'd0, instr}, o.val);
                    end
                end
                if (rdata_valid) begin
                    if (out_q.size() == 0 || out_q[0].is_instr) begin
                        check64("unexpected_rdata_valid", mm_rdata, 64'd0 - 64'd1);
                    end else begin
                        o = out_q.pop_front();
                        check64("mm_rdata", mm_rdata, o.val);
                    end
                end
                prev_stall = ARVALID && !ARREADY;
                prev_addr  = ARADDR;
                prev_iv    = instr_valid;
            end
        end
    end

    // One pipeline step: set requester inputs, queue expectations, wait for instr_valid.
    task automatic run_step(input logic [63:0] pc_v, input logic ren, input logic [63:0] maddr,
                            input logic [63:0] dd, input logic [63:0] di,
                            input int ard, input int rd, input logic [1:0] resp);
        bit got = 0;
        int rdv_n = -1;
        int gap = 0;
        int stalls = 0;
        pc       = pc_v;
        mm_ren   = ren;
        mm_addr  = maddr;
        data_d   = dd;
        data_i   = di;
        ar_delay = ard;
        r_delay  = rd;
        r_resp   = resp;
        if (ren) begin
            ar_q.push_back('{addr: maddr, id: 4'd1, size: 3'd3, prot: 3'd0});
            out_q.push_back('{is_instr: 1'b0, val: dd});
        end
        ar_q.push_back('{addr: pc_v, id: 4'd0, size: 3'd2, prot: 3'd4});
        out_q.push_back('{is_instr: 1'b1, val: {32'd0, (pc_v[2] ? di[63:32] : di[31:0])}});
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (ARVALID && !ARREADY) stalls++;
            if (rdata_valid) rdv_n = n;
            if (instr_valid) begin
                got = 1;
                gap = n - rdv_n;
                break;
            end
        end
        check64("step_done", {63'd0, got}, 64'd1);
        check64("ar_stall_cycles", stalls, ard * (ren ? 2 : 1));
        if (ren) check64("load_before_fetch_gap_ge3", {63'd0, (rdv_n >= 0 && gap >= 3)}, 64'd1);
    endtask

    initial begin
        bit got;
        repeat (3) @(negedge clk);
        check64("rst_arvalid", {63'd0, ARVALID}, 64'd0);
        check64("rst_rready", {63'd0, RREADY}, 64'd0);
        check64("rst_araddr", ARADDR, 64'd0);
        check64("rst_arid_size_prot", {ARID, ARSIZE, ARPORT}, 64'd0);
        check64("rst_instr", {32'd0, instr}, 64'h13);
        check64("rst_mm_rdata", mm_rdata, 64'd0);
        check64("rst_valids", {instr_valid, rdata_valid}, 64'd0);

        rst = 1'b0;
        run_step(64'h8000_0000, 1'b0, 64'd0, 64'd0, 64'h1111_1111_0010_0093, 0, 0, 2'b00);
        run_step(64'h8000_0004, 1'b0, 64'd0, 64'd0, 64'h1111_1111_0010_0093, 0, 0, 2'b00);
        run_step(64'h8000_0008, 1'b1, 64'h8000_1008, 64'hDEAD_BEEF_CAFE_F00D,
                 64'h0000_0517_0000_0297, 0, 0, 2'b00);
        run_step(64'h8000_000C, 1'b0, 64'd0, 64'd0, 64'hABCD_0123_4567_89EF, 5, 0, 2'b00);
        run_step(64'h8000_0010, 1'b0, 64'd0, 64'd0, 64'h0000_00B3_0040_8113, 0, 4, 2'b10);
        run_step(64'h8000_0020, 1'b1, 64'h8000_2000, 64'h0123_4567_89AB_CDEF,
                 64'h0020_0113_0030_0193, 0, 2, 2'b00);

        // Reset while the fetch beat is on the R channel.
        pc       = 64'h8000_0018;
        mm_ren   = 1'b0;
        data_i   = 64'h5555_5555_6666_6666;
        ar_delay = 0;
        r_delay  = 0;
        r_resp   = 2'b00;
        ar_q.push_back('{addr: 64'h8000_0018, id: 4'd0, size: 3'd2, prot: 3'd4});
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (RREADY && RVALID) begin
                got = 1;
                break;
            end
        end
        check64("reach_i_r", {63'd0, got}, 64'd1);
        rst = 1'b1;
        #1;
        check64("midrst_arvalid", {63'd0, ARVALID}, 64'd0);
        check64("midrst_rready", {63'd0, RREADY}, 64'd0);
        check64("midrst_instr", {32'd0, instr}, 64'h13);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check64("midrst_no_instr_valid", {63'd0, instr_valid}, 64'd0);
        end
        rst = 1'b0;
        run_step(64'h8000_0000, 1'b0, 64'd0, 64'd0, 64'h1111_1111_0010_0093, 0, 0, 2'b00);

        check64("ar_queue_empty", ar_q.size(), 64'd0);
        check64("out_queue_empty", out_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
